// File: rtl/sata_fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// sata_fifo_ptr_ctrl
//
// Single-clock pointer controller for a 4-entry SATA staging FIFO. The read
// and write pointers are 3-bit Gray counters (000,001,011,010,110,111,101,100).
// The extra wrap bit tells full apart from empty. The controller drives the
// write strobe and addresses of an external 4-entry register file that has an
// asynchronous read port, so the head entry is visible while o_valid is high.
//
// Ports:
//   i_clk            single clock, all state on the rising edge
//   i_rst_n          synchronous reset, active-low
//   i_put            producer requests a write this cycle
//   i_got            consumer takes the head entry this cycle
//   i_err_clr        clears the sticky error flags
//   o_mem_we         write strobe to the register file (put accepted)
//   o_mem_waddr      write address, binary
//   o_mem_raddr      read address of the head entry, binary
//   o_valid          head entry valid (not empty)
//   o_full           4 entries stored
//   o_empty          0 entries stored
//   o_almost_full    fill >= ALMOST_FULL_LEVEL
//   o_almost_empty   fill <= ALMOST_EMPTY_LEVEL
//   o_fill           entries stored, 0..4
//   o_wr_ptr_gray    write pointer, Gray
//   o_rd_ptr_gray    read pointer, Gray
//   o_overflow       sticky: put while full
//   o_underflow      sticky: got while empty
// ----------------------------------------------------------------------------
module sata_fifo_ptr_ctrl #(
    parameter int unsigned ALMOST_FULL_LEVEL  = 3,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_put,
    input  logic       i_got,
    input  logic       i_err_clr,
    output logic       o_mem_we,
    output logic [1:0] o_mem_waddr,
    output logic [1:0] o_mem_raddr,
    output logic       o_valid,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_almost_full,
    output logic       o_almost_empty,
    output logic [2:0] o_fill,
    output logic [2:0] o_wr_ptr_gray,
    output logic [2:0] o_rd_ptr_gray,
    output logic       o_overflow,
    output logic       o_underflow
);

    localparam logic [2:0] AfLevel = 3'(ALMOST_FULL_LEVEL);
    localparam logic [2:0] AeLevel = 3'(ALMOST_EMPTY_LEVEL);

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [2:0] r_wr_gray;
    logic [2:0] r_rd_gray;
    logic       r_overflow;
    logic       r_underflow;

    logic [2:0] w_wr_bin;
    logic [2:0] w_rd_bin;
    logic [2:0] w_wr_gray_nxt;
    logic [2:0] w_rd_gray_nxt;
    logic       w_full;
    logic       w_empty;
    logic       w_put_acc;
    logic       w_got_acc;
    logic       w_ovf_set;
    logic       w_unf_set;
    logic       w_overflow_nxt;
    logic       w_underflow_nxt;

    // Flags come only from the registered pointers, never from put/got.
    always_comb begin
        w_wr_bin = gray2bin(r_wr_gray);
        w_rd_bin = gray2bin(r_rd_gray);
        w_empty  = (r_wr_gray == r_rd_gray);
        // Full: wrap bits differ, index equal -> top two Gray bits inverted.
        w_full   = (r_wr_gray[2:1] == ~r_rd_gray[2:1]) && (r_wr_gray[0] == r_rd_gray[0]);
    end

    always_comb begin
        w_put_acc     = i_put & ~w_full;
        w_got_acc     = i_got & ~w_empty;
        // Advance in binary and re-encode so the pointer can only take legal codes.
        w_wr_gray_nxt = w_put_acc ? bin2gray(w_wr_bin + 3'd1) : r_wr_gray;
        w_rd_gray_nxt = w_got_acc ? bin2gray(w_rd_bin + 3'd1) : r_rd_gray;
    end

    // Sticky errors: set has priority over clear.
    always_comb begin
        w_ovf_set       = i_put & w_full;
        w_unf_set       = i_got & w_empty;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        if (i_err_clr) begin
            w_overflow_nxt  = 1'b0;
            w_underflow_nxt = 1'b0;
        end
        if (w_ovf_set) begin
            w_overflow_nxt = 1'b1;
        end
        if (w_unf_set) begin
            w_underflow_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_gray   <= 3'b000;
            r_rd_gray   <= 3'b000;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_gray   <= w_wr_gray_nxt;
            r_rd_gray   <= w_rd_gray_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    always_comb begin
        // Reset overrides a concurrent put, so no write reaches the register file.
        o_mem_we       = w_put_acc & i_rst_n;
        o_mem_waddr    = w_wr_bin[1:0];
        o_mem_raddr    = w_rd_bin[1:0];
        o_empty        = w_empty;
        o_full         = w_full;
        o_valid        = ~w_empty;
        o_fill         = w_wr_bin - w_rd_bin;
        o_almost_full  = (o_fill >= AfLevel);
        o_almost_empty = (o_fill <= AeLevel);
        o_wr_ptr_gray  = r_wr_gray;
        o_rd_ptr_gray  = r_rd_gray;
        o_overflow     = r_overflow;
        o_underflow    = r_underflow;
    end

endmodule

// File: tb/tb_sata_fifo_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sata_fifo_ptr_ctrl
//
// Directed vector table for the fill/overflow/drain/wrap/simultaneous/reset
// cases, followed by a randomized run against an occupancy-counting model.
// ----------------------------------------------------------------------------
module tb_sata_fifo_ptr_ctrl;

    logic       clk;
    logic       rst_n;
    logic       put;
    logic       got;
    logic       err_clr;
    logic       mem_we;
    logic [1:0] mem_waddr;
    logic [1:0] mem_raddr;
    logic       valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] fill;
    logic [2:0] wr_ptr_gray;
    logic [2:0] rd_ptr_gray;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    sata_fifo_ptr_ctrl #(
        .ALMOST_FULL_LEVEL (3),
        .ALMOST_EMPTY_LEVEL(1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_put         (put),
        .i_got         (got),
        .i_err_clr     (err_clr),
        .o_mem_we      (mem_we),
        .o_mem_waddr   (mem_waddr),
        .o_mem_raddr   (mem_raddr),
        .o_valid       (valid),
        .o_full        (full),
        .o_empty       (empty),
        .o_almost_full (almost_full),
        .o_almost_empty(almost_empty),
        .o_fill        (fill),
        .o_wr_ptr_gray (wr_ptr_gray),
        .o_rd_ptr_gray (rd_ptr_gray),
        .o_overflow    (overflow),
        .o_underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp, input int idx);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic       p, g, c, r;
        logic       we;
        logic [1:0] wa, ra;
        logic [2:0] fill;
        logic       full, empty, af, ae, ov, un;
        logic [2:0] wg, rg;
    } vec_t;

    // Columns: put got clr rst_n | we waddr raddr (before edge) |
    //          fill full empty af ae ov un wg rg (after edge)
    localparam int NV = 25;
    int tbl [NV][16] = '{
        '{0,0,0,0, 0,0,0, 0,0,1,0,1,0,0, 0,0},
        '{0,0,0,0, 0,0,0, 0,0,1,0,1,0,0, 0,0},
        '{0,0,0,1, 0,0,0, 0,0,1,0,1,0,0, 0,0},
        '{1,0,0,1, 1,0,0, 1,0,0,0,1,0,0, 1,0},
        '{1,0,0,1, 1,1,0, 2,0,0,0,0,0,0, 3,0},
        '{1,0,0,1, 1,2,0, 3,0,0,1,0,0,0, 2,0},
        '{1,0,0,1, 1,3,0, 4,1,0,1,0,0,0, 6,0},
        '{1,0,0,1, 0,0,0, 4,1,0,1,0,1,0, 6,0},
        '{0,0,0,1, 0,0,0, 4,1,0,1,0,1,0, 6,0},
        '{0,0,1,1, 0,0,0, 4,1,0,1,0,0,0, 6,0},
        '{0,1,0,1, 0,0,0, 3,0,0,1,0,0,0, 6,1},
        '{0,1,0,1, 0,0,1, 2,0,0,0,0,0,0, 6,3},
        '{0,1,0,1, 0,0,2, 1,0,0,0,1,0,0, 6,2},
        '{0,1,0,1, 0,0,3, 0,0,1,0,1,0,0, 6,6},
        '{0,1,0,1, 0,0,0, 0,0,1,0,1,0,1, 6,6},
        '{0,0,1,1, 0,0,0, 0,0,1,0,1,0,0, 6,6},
        '{1,1,0,1, 1,0,0, 1,0,0,0,1,0,1, 7,6},
        '{1,0,1,1, 1,1,0, 2,0,0,0,0,0,0, 5,6},
        '{1,1,0,1, 1,2,0, 2,0,0,0,0,0,0, 4,7},
        '{1,1,0,1, 1,3,1, 2,0,0,0,0,0,0, 0,5},
        '{1,0,0,1, 1,0,2, 3,0,0,1,0,0,0, 1,5},
        '{1,0,0,1, 1,1,2, 4,1,0,1,0,0,0, 3,5},
        '{1,1,0,1, 0,2,2, 3,0,0,1,0,1,0, 3,4},
        '{1,0,0,0, 0,2,3, 0,0,1,0,1,0,0, 0,0},
        '{0,0,0,1, 0,0,0, 0,0,1,0,1,0,0, 0,0}
    };

    function automatic vec_t row2vec(input int i);
        vec_t v;
        v.p = tbl[i][0][0];   v.g = tbl[i][1][0];   v.c = tbl[i][2][0];  v.r = tbl[i][3][0];
        v.we = tbl[i][4][0];  v.wa = 2'(tbl[i][5]); v.ra = 2'(tbl[i][6]);
        v.fill = 3'(tbl[i][7]);
        v.full = tbl[i][8][0]; v.empty = tbl[i][9][0]; v.af = tbl[i][10][0];
        v.ae = tbl[i][11][0];  v.ov = tbl[i][12][0];   v.un = tbl[i][13][0];
        v.wg = 3'(tbl[i][14]); v.rg = 3'(tbl[i][15]);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        put = v.p; got = v.g; err_clr = v.c; rst_n = v.r;
        #1;
        check("v_mem_we", int'(mem_we), int'(v.we), idx);
        if (v.r) begin
            check("v_waddr", int'(mem_waddr), int'(v.wa), idx);
            check("v_raddr", int'(mem_raddr), int'(v.ra), idx);
        end
        @(posedge clk);
        #1;
        check("v_fill", int'(fill), int'(v.fill), idx);
        check("v_full", int'(full), int'(v.full), idx);
        check("v_empty", int'(empty), int'(v.empty), idx);
        check("v_valid", int'(valid), int'(!v.empty), idx);
        check("v_almost_full", int'(almost_full), int'(v.af), idx);
        check("v_almost_empty", int'(almost_empty), int'(v.ae), idx);
        check("v_overflow", int'(overflow), int'(v.ov), idx);
        check("v_underflow", int'(underflow), int'(v.un), idx);
        check("v_wr_gray", int'(wr_ptr_gray), int'(v.wg), idx);
        check("v_rd_gray", int'(rd_ptr_gray), int'(v.rg), idx);
    endtask

    // ---------------- reference model ----------------
    // Tracks occupancy and how many entries have been written/read in total;
    // pointer codes come from the published Gray step sequence.
    int gray_seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int m_wr_cnt, m_rd_cnt, m_fill;
    bit m_ov, m_un;
    int step_no = 0;

    task automatic model_reset();
        m_wr_cnt = 0; m_rd_cnt = 0; m_fill = 0; m_ov = 0; m_un = 0;
    endtask

    task automatic rcycle(input bit p, input bit g, input bit c, input bit r);
        bit pacc, gacc;
        @(negedge clk);
        put = p; got = g; err_clr = c; rst_n = r;
        #1;
        step_no++;
        pacc = p && (m_fill < 4);
        gacc = g && (m_fill > 0);
        check("m_mem_we", int'(mem_we), int'(r && pacc), step_no);
        check("m_waddr", int'(mem_waddr), m_wr_cnt % 4, step_no);
        check("m_raddr", int'(mem_raddr), m_rd_cnt % 4, step_no);
        check("m_fill", int'(fill), m_fill, step_no);
        check("m_full", int'(full), int'(m_fill == 4), step_no);
        check("m_empty", int'(empty), int'(m_fill == 0), step_no);
        check("m_valid", int'(valid), int'(m_fill != 0), step_no);
        check("m_almost_full", int'(almost_full), int'(m_fill >= 3), step_no);
        check("m_almost_empty", int'(almost_empty), int'(m_fill <= 1), step_no);
        check("m_wr_gray", int'(wr_ptr_gray), gray_seq[m_wr_cnt % 8], step_no);
        check("m_rd_gray", int'(rd_ptr_gray), gray_seq[m_rd_cnt % 8], step_no);
        check("m_overflow", int'(overflow), int'(m_ov), step_no);
        check("m_underflow", int'(underflow), int'(m_un), step_no);
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            if (c) begin m_ov = 0; m_un = 0; end
            if (p && m_fill == 4) m_ov = 1;
            if (g && m_fill == 0) m_un = 1;
            if (pacc) m_wr_cnt++;
            if (gacc) m_rd_cnt++;
            m_fill = m_fill + int'(pacc) - int'(gacc);
        end
    endtask

    initial begin
        int pw, gw;
        put = 0; got = 0; err_clr = 0; rst_n = 0;

        for (int i = 0; i < NV; i++) begin
            run_vec(row2vec(i), i);
        end

        // Model-checked sequences: reset, fill to 2, five simultaneous put/got.
        model_reset();
        rcycle(0, 0, 0, 0);
        rcycle(0, 0, 0, 0);
        rcycle(1, 0, 0, 1);
        rcycle(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) rcycle(1, 1, 0, 1);
        // Reset mid-operation with fill=3 and a concurrent put.
        rcycle(1, 0, 0, 1);
        rcycle(1, 0, 0, 0);
        rcycle(0, 0, 0, 1);

        // Randomized run with phases biased toward filling or draining.
        for (int i = 0; i < 3000; i++) begin
            if ((i / 100) % 2 == 0) begin pw = 70; gw = 35; end
            else begin pw = 35; gw = 70; end
            rcycle($urandom_range(0, 99) < pw,
                   $urandom_range(0, 99) < gw,
                   $urandom_range(0, 99) < 8,
                   $urandom_range(0, 199) != 0);
        end
        rcycle(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
